// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ecc_pkg
// Brief   : Shared widths and FSM encoding for the ECC encode arbiter slice.
// Revision: 1.0
// ============================================================================
package ecc_pkg;

    localparam int DATA_W = 32;
    localparam int CODE_W = 38;
    localparam int PAR_W  = 6;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/ecc_encode_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational round-robin picker, searches from last_i+1 upward.
// Revision: 1.0
// ============================================================================
module rr_pick #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] sel_o,
    output logic          any_o
);

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        int idx;
        sel_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_i) + k) % N;
            if (req_i[idx]) begin
                sel_o = IW'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/encoder.sv
`default_nettype none
// ============================================================================
// Module  : encoder
// Brief   : Combinational Hamming(38,32) encoder, code bit p-1 holds position p.
// Revision: 1.0
// ============================================================================
module encoder
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] data_out
);

    // Parity vector is the XOR of the positions of all set data bits.
    always_comb begin
        logic [PAR_W-1:0] syn;
        int               di;
        data_out = '0;
        syn      = '0;
        di       = 0;
        for (int pos = 1; pos <= CODE_W; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                data_out[pos-1] = data_in[di];
                if (data_in[di]) begin
                    syn = syn ^ PAR_W'(pos);
                end
                di = di + 1;
            end
        end
        for (int k = 0; k < PAR_W; k++) begin
            data_out[(1 << k) - 1] = syn[k];
        end
    end

endmodule : encoder
`default_nettype wire

// File: rtl/ecc_encode_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ecc_encode_arbiter
// Brief   : Shares one Hamming(38,32) encoder among NUM_REQ write requesters.
// Revision: 1.0
// ============================================================================
module ecc_encode_arbiter
    import ecc_pkg::*;
#(
    parameter int  NUM_REQ   = 2,
    parameter int  BURST_LEN = 1,
    parameter int  CNT_W     = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [CODE_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_src,
    input  logic                      out_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          enc_count
);

    localparam int                BCNT_W      = $clog2(BURST_LEN + 1);
    localparam logic [BCNT_W-1:0] c_burst_len = BCNT_W'(BURST_LEN);

    state_e              state_q,     state_d;
    logic [BCNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [ID_W-1:0]     last_gnt_q,  last_gnt_d;
    logic [ID_W-1:0]     gnt_q,       gnt_d;
    logic                out_valid_q, out_valid_d;
    logic [CODE_W-1:0]   out_data_q,  out_data_d;
    logic [ID_W-1:0]     out_src_q,   out_src_d;
    logic [CNT_W-1:0]    enc_count_q, enc_count_d;

    logic [ID_W-1:0]     w_pick_sel;
    logic                w_pick_any;
    logic [ID_W-1:0]     w_sel;
    logic                w_sel_ok;
    logic                w_load_en;
    logic                w_xfer;
    logic [BCNT_W-1:0]   w_beat_inc;
    logic [DATA_W-1:0]   w_sel_data;
    logic [CODE_W-1:0]   w_code;

    rr_pick #(
        .N      (NUM_REQ)
    ) u_rr_pick (
        .req_i  (req_valid),
        .last_i (last_gnt_q),
        .sel_o  (w_pick_sel),
        .any_o  (w_pick_any)
    );

    assign w_load_en = !out_valid_q || out_ready;

    always_comb begin
        w_sel    = w_pick_sel;
        w_sel_ok = w_pick_any;
        if (state_q == LOCKED) begin
            w_sel    = gnt_q;
            w_sel_ok = req_valid[gnt_q];
        end
    end

    assign w_xfer     = w_sel_ok && w_load_en;
    assign w_sel_data = req_data[w_sel*DATA_W +: DATA_W];

    // Ready is held low throughout reset so no requester sees a phantom accept.
    always_comb begin
        req_ready = '0;
        if (rst_n && w_load_en && ((state_q == LOCKED) || w_pick_any)) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    encoder u_encoder (
        .data_in  (w_sel_data),
        .data_out (w_code)
    );

    assign w_beat_inc = beat_cnt_q + BCNT_W'(1);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    last_gnt_d = w_sel;
                    gnt_d      = w_sel;
                    if (BURST_LEN > 1) begin
                        state_d    = LOCKED;
                        beat_cnt_d = BCNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // A dropped valid releases the lock even while stalled downstream.
                if (!req_valid[gnt_q]) begin
                    state_d    = IDLE;
                    beat_cnt_d = '0;
                end else if (w_xfer) begin
                    if (w_beat_inc == c_burst_len) begin
                        state_d    = IDLE;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = w_beat_inc;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = w_code;
            out_src_d   = w_sel;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        enc_count_d = enc_count_q;
        if (out_valid_q && out_ready) begin
            enc_count_d = enc_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            last_gnt_q  <= ID_W'(NUM_REQ - 1);
            gnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            enc_count_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            enc_count_q <= enc_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign enc_count = enc_count_q;
    assign busy      = (state_q == LOCKED) || out_valid_q;

endmodule : ecc_encode_arbiter
`default_nettype wire

// File: tb/tb_ecc_encode_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ecc_encode_arbiter
// Brief   : Two arbiters (BURST_LEN 1 and 4) checked against a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_ecc_encode_arbiter;

    localparam int NR = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic [NR-1:0]    req_valid [2];
    logic [NR*32-1:0] req_data  [2];
    logic             out_ready [2];

    logic [NR-1:0] req_ready0, req_ready1;
    logic          out_valid0, out_valid1;
    logic [37:0]   out_data0,  out_data1;
    logic          out_src0,   out_src1;
    logic          busy0,      busy1;
    logic [3:0]    enc_count0;
    logic [15:0]   enc_count1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int          m_last  [2];
    int          m_owner [2];
    int          m_beats [2];
    int          m_os    [2];
    int          m_cnt   [2];
    bit          m_ov    [2];
    logic [37:0] m_od    [2];
    int          burst    [2] = '{1, 4};
    int          cnt_mask [2] = '{15, 65535};
    int          seqn [2][NR];

    int src_log0[$];
    int src_log1[$];
    int acc_cyc1[$];

    always #5 clk = ~clk;

    ecc_encode_arbiter #(.NUM_REQ(NR), .BURST_LEN(1), .CNT_W(4)) u_dut_b1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_data(req_data[0]),
        .req_ready(req_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_src(out_src0), .out_ready(out_ready[0]), .busy(busy0), .enc_count(enc_count0)
    );

    ecc_encode_arbiter #(.NUM_REQ(NR), .BURST_LEN(4), .CNT_W(16)) u_dut_b4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_data(req_data[1]),
        .req_ready(req_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_src(out_src1), .out_ready(out_ready[1]), .busy(busy1), .enc_count(enc_count1)
    );

    function automatic void chk(string name, int d, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got 0x%0h, want 0x%0h", name, d, $time, got, exp);
        end
    endfunction

    // Textbook Hamming: data fills non-power-of-two positions, parity k covers positions with bit k set.
    function automatic logic [37:0] enc_model(logic [31:0] x);
        logic [37:0] c;
        int          j;
        logic        b;
        c = '0;
        j = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p-1] = x[j];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            b = 1'b0;
            for (int p = 1; p <= 38; p++) begin
                if ((p & (1 << k)) != 0) b = b ^ c[p-1];
            end
            c[(1 << k) - 1] = b;
        end
        return c;
    endfunction

    function automatic int rr_first(logic [NR-1:0] v, int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    function automatic void model_reset(int d);
        m_last[d]  = NR - 1;
        m_owner[d] = -1;
        m_beats[d] = 0;
        m_ov[d]    = 1'b0;
        m_od[d]    = '0;
        m_os[d]    = 0;
        m_cnt[d]   = 0;
    endfunction

    function automatic void model_step(int d, logic [NR-1:0] act_rdy);
        bit            load;
        int            sel;
        bit            dropped;
        logic [NR-1:0] exp_rdy;
        load    = !m_ov[d] || out_ready[d];
        sel     = -1;
        dropped = 1'b0;
        exp_rdy = '0;
        if (m_owner[d] >= 0) begin
            exp_rdy[m_owner[d]] = load;
            if (req_valid[d][m_owner[d]]) sel = m_owner[d];
            else dropped = 1'b1;
        end else begin
            sel = rr_first(req_valid[d], m_last[d]);
            if (sel >= 0) exp_rdy[sel] = load;
        end
        chk("req_ready", d, act_rdy, exp_rdy);
        if (m_ov[d] && out_ready[d]) m_cnt[d] = (m_cnt[d] + 1) & cnt_mask[d];
        if (dropped) begin
            m_owner[d] = -1;
            m_beats[d] = 0;
        end
        if (sel >= 0 && load) begin
            if (m_owner[d] < 0) begin
                m_last[d] = sel;
                if (burst[d] > 1) begin
                    m_owner[d] = sel;
                    m_beats[d] = 1;
                end
            end else begin
                m_beats[d]++;
                if (m_beats[d] == burst[d]) begin
                    m_owner[d] = -1;
                    m_beats[d] = 0;
                end
            end
            m_ov[d] = 1'b1;
            m_od[d] = enc_model(req_data[d][32*sel +: 32]);
            m_os[d] = sel;
        end else if (out_ready[d]) begin
            m_ov[d] = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic [NR-1:0] a_rdy;
            logic          a_v;
            logic [37:0]   a_d;
            logic          a_s;
            logic          a_b;
            int            a_c;
            if (d == 0) begin
                a_rdy = req_ready0; a_v = out_valid0; a_d = out_data0;
                a_s = out_src0; a_b = busy0; a_c = int'(enc_count0);
            end else begin
                a_rdy = req_ready1; a_v = out_valid1; a_d = out_data1;
                a_s = out_src1; a_b = busy1; a_c = int'(enc_count1);
            end
            if (!rst_n) begin
                model_reset(d);
                chk("rst_req_ready", d, a_rdy, '0);
                chk("rst_out_valid", d, a_v, 0);
                chk("rst_out_data", d, a_d, 0);
                chk("rst_out_src", d, a_s, 0);
                chk("rst_busy", d, a_b, 0);
                chk("rst_enc_count", d, a_c, 0);
            end else begin
                chk("out_valid", d, a_v, m_ov[d]);
                chk("out_data", d, a_d, m_od[d]);
                chk("out_src", d, a_s, m_os[d]);
                chk("busy", d, a_b, (m_owner[d] >= 0) || m_ov[d]);
                chk("enc_count", d, a_c, m_cnt[d]);
                if (a_v && out_ready[d]) begin
                    if (d == 0) begin
                        src_log0.push_back(int'(a_s));
                    end else begin
                        src_log1.push_back(int'(a_s));
                        acc_cyc1.push_back(cyc);
                    end
                end
                model_step(d, a_rdy);
            end
        end
    end

    function automatic void clear_logs();
        src_log0.delete();
        src_log1.delete();
        acc_cyc1.delete();
    endfunction

    task automatic sync_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = '1;
            out_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) req_valid[d] = '0;
        clear_logs();
    endtask

    // Per-requester data changes only after an accepted beat; valid never looks at ready.
    task automatic run_phase(input int ncyc, input int pv, input int pdrop, input int pr,
                             input bit seqdata, input int quota0,
                             input int stall_lo, input int stall_hi);
        logic [NR-1:0] fired [2];
        int            sent  [2][NR];
        for (int d = 0; d < 2; d++) begin
            fired[d] = '0;
            for (int i = 0; i < NR; i++) begin
                sent[d][i] = 0;
                seqn[d][i] = 1;
                req_data[d][32*i +: 32] = seqdata ? {4'(i + 1), 28'(0)} : $urandom;
            end
        end
        for (int c = 0; c < ncyc; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NR; i++) begin
                    if (fired[d][i]) begin
                        sent[d][i]++;
                        req_data[d][32*i +: 32] = seqdata ? {4'(i + 1), 28'(seqn[d][i])} : $urandom;
                        seqn[d][i]++;
                    end
                    if (i == 0 && quota0 >= 0 && sent[d][0] >= quota0)
                        req_valid[d][i] = 1'b0;
                    else if (fired[d][i] || !req_valid[d][i])
                        req_valid[d][i] = ($urandom_range(99) < pv);
                    else if ($urandom_range(99) < pdrop)
                        req_valid[d][i] = 1'b0;
                end
                out_ready[d] = (c >= stall_lo && c < stall_hi) ? 1'b0 : ($urandom_range(99) < pr);
            end
            @(negedge clk);
            fired[0] = req_valid[0] & req_ready0;
            fired[1] = req_valid[1] & req_ready1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_seq(string name, int d, int n, int pattern);
        int got;
        int want;
        chk({name, "_len"}, d, ((d == 0 ? src_log0.size() : src_log1.size()) >= n), 1);
        for (int k = 0; k < n; k++) begin
            if (d == 0) got = (k < src_log0.size()) ? src_log0[k] : -1;
            else        got = (k < src_log1.size()) ? src_log1[k] : -1;
            want = (pattern == 0) ? (k % 2) : ((k < 4) ? 0 : 1);
            chk(name, d, got, want);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = '1;
            req_data[d]  = '0;
            out_ready[d] = 1'b1;
            model_reset(d);
        end

        chk("enc_model_d0", 0, enc_model(32'h0000_0001), 38'h7);
        chk("enc_model_d1", 0, enc_model(32'h0000_0002), 38'h19);
        chk("enc_model_d31", 0, enc_model(32'h8000_0000), 38'h20_8000_000A);

        // Reset held with every requester valid.
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single word from requester 0.
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 2'b01;
            req_data[d]  = {32'h0, 32'hCAFE3475};
            out_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) req_valid[d] = '0;
        @(negedge clk);
        chk("t2_valid", 0, out_valid0, 1);
        chk("t2_src", 0, out_src0, 0);
        chk("t2_data", 0, out_data0, enc_model(32'hCAFE3475));
        chk("t2_valid", 1, out_valid1, 1);
        chk("t2_src", 1, out_src1, 0);
        chk("t2_data", 1, out_data1, enc_model(32'hCAFE3475));
        @(posedge clk);
        #1;
        chk("t2_count", 0, enc_count0, 1);
        chk("t2_count", 1, enc_count1, 1);

        // Continuous traffic: alternate vs. burst-of-four.
        sync_reset();
        run_phase(12, 100, 0, 100, 1'b1, -1, 0, 0);
        check_seq("t3_rr_src", 0, 8, 0);
        check_seq("t4_burst_src", 1, 8, 1);

        // Requester 0 gives up after two beats of its burst.
        sync_reset();
        run_phase(10, 100, 0, 100, 1'b1, 2, 0, 0);
        chk("t4_drop_len", 1, src_log1.size() >= 3, 1);
        if (src_log1.size() >= 3) begin
            chk("t4_drop_src2", 1, src_log1[2], 1);
            chk("t4_drop_gap", 1, acc_cyc1[2] - acc_cyc1[1], 2);
        end

        // Five cycles of downstream stall inside the first burst.
        sync_reset();
        run_phase(16, 100, 0, 100, 1'b1, -1, 2, 7);
        check_seq("t5_stall_src", 1, 8, 1);
        check_seq("t5_stall_rr", 0, 8, 0);

        // Asynchronous reset pulse between clock edges mid-burst.
        sync_reset();
        run_phase(3, 100, 0, 100, 1'b1, -1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_valid", 0, out_valid0, 0);
        chk("t6_valid", 1, out_valid1, 0);
        chk("t6_data", 1, out_data1, 0);
        chk("t6_busy", 1, busy1, 0);
        chk("t6_count", 0, enc_count0, 0);
        chk("t6_count", 1, enc_count1, 0);
        for (int d = 0; d < 2; d++) model_reset(d);
        #1 rst_n = 1'b1;
        clear_logs();
        run_phase(10, 100, 0, 100, 1'b1, -1, 0, 0);
        check_seq("t6_post_rr", 0, 4, 0);
        check_seq("t6_post_burst", 1, 4, 1);

        // Randomized traffic, including counter wrap on the 4-bit instance.
        sync_reset();
        run_phase(800, 70, 10, 75, 1'b0, -1, 0, 0);
        run_phase(300, 90, 5, 95, 1'b0, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ecc_encode_arbiter
`default_nettype wire
